// File: rtl/alu_console_pkg.sv
// Shared definitions for the ALU switch console: size helpers and the
// step-class decode used to pick the action of a forward press.
package alu_console_pkg;

    // What a forward press does at a given step index.
    typedef enum logic [2:0] {
        ST_LOAD_A,
        ST_LOAD_B,
        ST_LOAD_F,
        ST_SHOW_S,
        ST_SHOW_Z,
        ST_SHOW_N
    } step_class_e;

    // Number of switch-wide chunks in one operand.
    function automatic int NC_OF(input int data_w, input int sw_w);
        return data_w / sw_w;
    endfunction

    // Index of the final step (negative-flag display).
    function automatic int LAST_OF(input int nc);
        return 3 * nc + 2;
    endfunction

    // Width of the step counter for a given last index.
    function automatic int STEP_W_OF(input int last);
        return (last < 1) ? 1 : $clog2(last + 1);
    endfunction

    // Step counter width for the default 32-bit / 16-switch build.
    localparam int DEF_STEP_W = STEP_W_OF(LAST_OF(NC_OF(32, 16)));

    // Map a step index onto its action class.
    function automatic step_class_e class_of(input int k, input int nc);
        if (k < nc)               return ST_LOAD_A;
        else if (k < 2 * nc)      return ST_LOAD_B;
        else if (k == 2 * nc)     return ST_LOAD_F;
        else if (k <= 3 * nc)     return ST_SHOW_S;
        else if (k == 3 * nc + 1) return ST_SHOW_Z;
        else                      return ST_SHOW_N;
    endfunction

endpackage

// File: rtl/alu_console_seq_btn.sv
// Button conditioner: 2-flop synchroniser, stable-level debounce and a
// one-cycle press pulse. A button already held when reset releases is
// ignored until it has been seen released.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg, sync2_reg;
    logic             valid1_reg, valid2_reg;
    logic             level_reg;
    logic             armed_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Synchronise, debounce, and emit a pulse on an accepted 0->1 change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            valid1_reg <= 1'b0;
            valid2_reg <= 1'b0;
            level_reg  <= 1'b0;
            armed_reg  <= 1'b0;
            press_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg  <= raw;
            sync2_reg  <= sync1_reg;
            // valid2 marks when sync2 reflects the real pin, not reset fill
            valid1_reg <= 1'b1;
            valid2_reg <= valid1_reg;
            press_reg  <= 1'b0;
            if (valid2_reg && !sync2_reg)
                armed_reg <= 1'b1;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
                if (sync2_reg && armed_reg)
                    press_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/alu_console_seq.sv
// Switch/button console for an external ALU: forward presses load A, B and
// the function code chunk by chunk, then step a frozen result snapshot and
// the Z/N flags onto the display. A back button steps the index backward.
// Optional feature macro: ALU_CONSOLE_ECHO_EN (echo loaded switches on out).
module alu_console_seq
    import alu_console_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int SW_W            = 16,
    parameter int FUNCT_W         = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    localparam int NC     = NC_OF(DATA_W, SW_W),
    localparam int LAST   = LAST_OF(NC),
    localparam int STEP_W = STEP_W_OF(LAST)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SW_W-1:0]    switch,
    input  logic               btn,
    input  logic               btn_back,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [FUNCT_W-1:0] alu_funct,
    input  logic [DATA_W-1:0]  alu_s,
    input  logic               alu_z,
    input  logic               alu_n,
    output logic [SW_W-1:0]    out,
    output logic [STEP_W-1:0]  step
);

    localparam logic [STEP_W-1:0] LAST_S = STEP_W'(LAST);

    logic               press_fwd, press_back;
    logic               fwd_only, back_only;
    logic [STEP_W-1:0]  step_reg;
    logic [DATA_W-1:0]  alu_a_reg, alu_b_reg, res_s_reg;
    logic [FUNCT_W-1:0] alu_funct_reg;
    logic [SW_W-1:0]    out_reg;
    logic               res_z_reg, res_n_reg, cap_reg;
    step_class_e        step_cls;
    logic [SW_W-1:0]    res_chunk [NC];

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_fwd (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn),
        .press (press_fwd)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_back (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_back),
        .press (press_back)
    );

    // Simultaneous presses cancel each other out.
    assign fwd_only  = press_fwd && !press_back;
    assign back_only = press_back && !press_fwd;
    assign step_cls  = class_of(int'(step_reg), NC);

    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_res_chunk
            assign res_chunk[gi] = res_s_reg[SW_W*gi +: SW_W];
        end
    endgenerate

    // Step sequencing, operand loads, snapshot capture and display update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_reg      <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_funct_reg <= '0;
            out_reg       <= '0;
            res_s_reg     <= '0;
            res_z_reg     <= 1'b0;
            res_n_reg     <= 1'b0;
            cap_reg       <= 1'b0;
        end else begin
            // The ALU sees the new funct one cycle after the load, so the
            // snapshot is taken on the cycle after that press.
            cap_reg <= fwd_only && (step_cls == ST_LOAD_F);
            if (cap_reg) begin
                res_s_reg <= alu_s;
                res_z_reg <= alu_z;
                res_n_reg <= alu_n;
            end
            if (back_only) begin
                step_reg <= (step_reg == '0) ? LAST_S : step_reg - 1'b1;
            end else if (fwd_only) begin
                step_reg <= (step_reg == LAST_S) ? '0 : step_reg + 1'b1;
`ifdef ALU_CONSOLE_ECHO_EN
                if (step_cls == ST_LOAD_A || step_cls == ST_LOAD_B || step_cls == ST_LOAD_F)
                    out_reg <= switch;
`endif
                case (step_cls)
                    ST_LOAD_A: begin
                        for (int i = 0; i < NC; i++)
                            if (step_reg == STEP_W'(i))
                                alu_a_reg[SW_W*i +: SW_W] <= switch;
                    end
                    ST_LOAD_B: begin
                        for (int i = 0; i < NC; i++)
                            if (step_reg == STEP_W'(NC + i))
                                alu_b_reg[SW_W*i +: SW_W] <= switch;
                    end
                    ST_LOAD_F: alu_funct_reg <= switch[FUNCT_W-1:0];
                    ST_SHOW_S: begin
                        for (int i = 0; i < NC; i++)
                            if (step_reg == STEP_W'(2*NC + 1 + i))
                                out_reg <= res_chunk[i];
                    end
                    ST_SHOW_Z: out_reg <= {{(SW_W-1){1'b0}}, res_z_reg};
                    default:   out_reg <= {{(SW_W-1){1'b0}}, res_n_reg};
                endcase
            end
        end
    end

    assign step      = step_reg;
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_funct = alu_funct_reg;
    assign out       = out_reg;

endmodule
